// File: rtl/spi_pkg.sv
// Shared SPI link constants: FSM encoding, frame geometry and the default
// underrun byte. Used by both the master and spi_slave.
package spi_pkg;
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
    localparam logic [STATE_W-1:0] ST_SELECTED = 2'd1;

    localparam int FRAME_W = 8;
    localparam int CNT_W   = 3;

    localparam logic [FRAME_W-1:0] UNDERRUN_DEFAULT = 8'hFF;
endpackage

// File: rtl/spi_sync.sv
// Single-bit STAGES-deep synchronizer with a configurable async reset value.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= {STAGES{RST_VAL}};
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave, oversampled on clk, with a single-entry tx holding register.
// Optional SPI_SLAVE_MISO_TRISTATE_EN releases miso to Z while not selected.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                 SYNC_STAGES   = 2,
    parameter logic [FRAME_W-1:0] UNDERRUN_BYTE = UNDERRUN_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ss_n,
    input  logic               sck,
    input  logic               mosi,
    output logic               miso,
    input  logic [FRAME_W-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [FRAME_W-1:0] rx_data,
    output logic               new_data,
    output logic               busy
);
    logic ss_s, sck_s, mosi_s;
    logic ss_d, sck_d;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst(rst), .d(ss_n), .q(ss_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst(rst), .d(sck),  .q(sck_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] rx_shift, tx_shift, hold_data;
    logic               hold_full;

    logic sck_rise, sck_fall, ss_fall, ss_rise, sel, accept, load, shift;

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ss_fall  = ~ss_s & ss_d;
    assign ss_rise  = ss_s & ~ss_d;
    assign sel      = (state == ST_SELECTED);

    assign tx_ready = ~hold_full;
    assign accept   = tx_valid & ~hold_full;
    // Counter at 0 on a fall means a byte just completed: refill for back-to-back frames.
    assign load     = ((state == ST_IDLE) & ss_fall) |
                      (sel & ~ss_rise & sck_fall & (cnt == '0));
    assign shift    = sel & ~ss_rise & sck_fall & (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            rx_data   <= '0;
            new_data  <= 1'b0;
            hold_data <= '0;
            hold_full <= 1'b0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sck_d    <= sck_s;
            ss_d     <= ss_s;
            new_data <= 1'b0;

            // accept requires an empty register, so it never collides with a draining load
            if (accept) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end

            if (load) begin
                if (hold_full) begin
                    tx_shift  <= hold_data;
                    hold_full <= 1'b0;
                end else begin
                    tx_shift  <= UNDERRUN_BYTE;
                end
            end else if (shift) begin
                tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
            end

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (ss_fall) state <= ST_SELECTED;
                end
                ST_SELECTED: begin
                    if (ss_rise) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[FRAME_W-2:0], mosi_s};
                        cnt      <= cnt + 1'b1;
                        if (cnt == CNT_W'(FRAME_W - 1)) begin
                            rx_data  <= {rx_shift[FRAME_W-2:0], mosi_s};
                            new_data <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = sel;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso = sel ? tx_shift[FRAME_W-1] : 1'bz;
`else
    assign miso = sel & tx_shift[FRAME_W-1];
`endif
endmodule
